// File: rtl/controller_unit.sv
// Microcoded control sequencer for the accumulator CPU: walks each instruction
// through fetch, decode, operand-fetch and execute micro-steps, one state per clock.
// Latency: implied ops 4 cycles, JMP/JZ 7, memory/ALU ops 9; HALT parks until reset.
// Backpressure: none; no wait states or handshakes, opcode sampled combinationally.
//
// Ports:
//   clk, res (async active-high)       clock and reset
//   opcode[7:0]                         current IR contents
//   ac_source/write_ac                  AC mux select and load enable
//   mar_source/write_mar                MAR mux select and load enable
//   mdr_source/write_mdr                MDR mux select and load enable
//   write_flags                         FLAGS load from ALU status
//   pc_source/write_pc                  PC mux select and load enable
//   write_ir, write_mem                 IR load from MDR, memory write
//   ALU_op_select, ALUctl               ALU B operand select and ALU operation
module controller_unit (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] opcode,
  output logic [1:0] ac_source,
  output logic       write_ac,
  output logic       mar_source,
  output logic       write_mar,
  output logic [1:0] mdr_source,
  output logic       write_mdr,
  output logic       write_flags,
  output logic [1:0] pc_source,
  output logic       write_pc,
  output logic       write_ir,
  output logic       write_mem,
  output logic [2:0] ALU_op_select,
  output logic [2:0] ALUctl
);

  // Micro-states
  localparam logic [3:0] ST_RST = 4'd0;
  localparam logic [3:0] ST_F0  = 4'd1;
  localparam logic [3:0] ST_F1  = 4'd2;
  localparam logic [3:0] ST_F2  = 4'd3;
  localparam logic [3:0] ST_DEC = 4'd4;
  localparam logic [3:0] ST_A0  = 4'd5;
  localparam logic [3:0] ST_A1  = 4'd6;
  localparam logic [3:0] ST_A2  = 4'd7;
  localparam logic [3:0] ST_A3  = 4'd8;
  localparam logic [3:0] ST_A4  = 4'd9;
  localparam logic [3:0] ST_HLT = 4'd10;

  // Opcodes
  localparam logic [7:0] OP_CLR   = 8'h01;
  localparam logic [7:0] OP_NOT   = 8'h02;
  localparam logic [7:0] OP_LOAD  = 8'h03;
  localparam logic [7:0] OP_STORE = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_SUB   = 8'h06;
  localparam logic [7:0] OP_AND   = 8'h07;
  localparam logic [7:0] OP_OR    = 8'h08;
  localparam logic [7:0] OP_XOR   = 8'h09;
  localparam logic [7:0] OP_INC   = 8'h0A;
  localparam logic [7:0] OP_DEC   = 8'h0B;
  localparam logic [7:0] OP_JMP   = 8'h0C;
  localparam logic [7:0] OP_JZ    = 8'h0D;
  localparam logic [7:0] OP_HALT  = 8'h0E;

  logic [3:0] state_q, state_d;
  logic       is_addr_op;
  logic       is_alu_op;

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_RST;
    else     state_q <= state_d;
  end

  // Ops carrying an address byte after the opcode
  assign is_addr_op = ((opcode >= OP_LOAD) && (opcode <= OP_XOR)) ||
                      (opcode == OP_JMP) || (opcode == OP_JZ);
  assign is_alu_op  = (opcode >= OP_ADD) && (opcode <= OP_XOR);

  always_comb begin
    state_d       = state_q;
    ac_source     = 2'd0;
    write_ac      = 1'b0;
    mar_source    = 1'b0;
    write_mar     = 1'b0;
    mdr_source    = 2'd0;
    write_mdr     = 1'b0;
    write_flags   = 1'b0;
    pc_source     = 2'd0;
    write_pc      = 1'b0;
    write_ir      = 1'b0;
    write_mem     = 1'b0;
    ALU_op_select = 3'd0;
    ALUctl        = 3'd0;

    case (state_q)
      ST_RST: begin
        write_pc  = 1'b1;
        pc_source = 2'd3;
        write_ac  = 1'b1;
        ac_source = 2'd2;
        state_d   = ST_F0;
      end
      ST_F0: begin
        write_mar = 1'b1;
        state_d   = ST_F1;
      end
      ST_F1: begin
        write_mdr = 1'b1;
        write_pc  = 1'b1;
        state_d   = ST_F2;
      end
      ST_F2: begin
        write_ir = 1'b1;
        state_d  = ST_DEC;
      end
      ST_DEC: begin
        state_d = is_addr_op ? ST_A0 : ST_F0;
        case (opcode)
          OP_CLR: begin
            write_ac  = 1'b1;
            ac_source = 2'd2;
          end
          OP_NOT: begin
            write_ac    = 1'b1;
            ALUctl      = 3'd5;
            write_flags = 1'b1;
          end
          OP_INC, OP_DEC: begin
            write_ac      = 1'b1;
            ALU_op_select = 3'd1;
            ALUctl        = (opcode == OP_DEC) ? 3'd1 : 3'd0;
            write_flags   = 1'b1;
          end
          OP_HALT: state_d = ST_HLT;
          default: ;
        endcase
      end
      ST_A0: begin
        write_mar = 1'b1;
        state_d   = ST_A1;
      end
      ST_A1: begin
        write_mdr = 1'b1;
        write_pc  = 1'b1;
        state_d   = ST_A2;
      end
      ST_A2: begin
        if (opcode == OP_JMP) begin
          write_pc  = 1'b1;
          pc_source = 2'd1;
          state_d   = ST_F0;
        end else if (opcode == OP_JZ) begin
          // Datapath resolves the Z-flag condition on pc_source=2
          write_pc  = 1'b1;
          pc_source = 2'd2;
          state_d   = ST_F0;
        end else begin
          write_mar  = 1'b1;
          mar_source = 1'b1;
          state_d    = ST_A3;
        end
      end
      ST_A3: begin
        write_mdr  = 1'b1;
        mdr_source = (opcode == OP_STORE) ? 2'd1 : 2'd0;
        state_d    = ST_A4;
      end
      ST_A4: begin
        state_d = ST_F0;
        if (opcode == OP_STORE) begin
          write_mem = 1'b1;
        end else if (opcode == OP_LOAD) begin
          write_ac  = 1'b1;
          ac_source = 2'd1;
        end else if (is_alu_op) begin
          write_ac    = 1'b1;
          write_flags = 1'b1;
          // ADD..XOR (5..9) map to ALU ops 0..4; modulo-8 subtract on low bits suffices
          ALUctl      = opcode[2:0] - 3'd5;
        end
      end
      ST_HLT: state_d = ST_HLT;
      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_controller_unit.sv
module tb_controller_unit;

  typedef struct packed {
    logic [1:0] ac_src;
    logic       wr_ac;
    logic       mar_src;
    logic       wr_mar;
    logic [1:0] mdr_src;
    logic       wr_mdr;
    logic       wr_flags;
    logic [1:0] pc_src;
    logic       wr_pc;
    logic       wr_ir;
    logic       wr_mem;
    logic [2:0] alu_b;
    logic [2:0] alu_ctl;
  } out_t;

  logic       clk;
  logic       res;
  logic [7:0] opcode;
  logic [1:0] ac_source;
  logic       write_ac;
  logic       mar_source;
  logic       write_mar;
  logic [1:0] mdr_source;
  logic       write_mdr;
  logic       write_flags;
  logic [1:0] pc_source;
  logic       write_pc;
  logic       write_ir;
  logic       write_mem;
  logic [2:0] ALU_op_select;
  logic [2:0] ALUctl;

  out_t got;
  out_t exp_q[$];
  int   n_chk;
  int   n_bad;

  controller_unit dut (
    .clk(clk), .res(res), .opcode(opcode),
    .ac_source(ac_source), .write_ac(write_ac),
    .mar_source(mar_source), .write_mar(write_mar),
    .mdr_source(mdr_source), .write_mdr(write_mdr),
    .write_flags(write_flags),
    .pc_source(pc_source), .write_pc(write_pc),
    .write_ir(write_ir), .write_mem(write_mem),
    .ALU_op_select(ALU_op_select), .ALUctl(ALUctl)
  );

  assign got = {ac_source, write_ac, mar_source, write_mar, mdr_source, write_mdr,
                write_flags, pc_source, write_pc, write_ir, write_mem,
                ALU_op_select, ALUctl};

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: bench timed out, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input out_t obs, input out_t expv);
    n_chk++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, expv);
    end
  endtask

  function automatic out_t rst_vec();
    out_t v = '0;
    v.wr_pc = 1'b1; v.pc_src = 2'd3; v.wr_ac = 1'b1; v.ac_src = 2'd2;
    return v;
  endfunction

  // Reference model: per-cycle control words of one whole instruction, from the ISA rules.
  task automatic build_seq(input logic [7:0] op);
    out_t v;
    exp_q.delete();
    v = '0; v.wr_mar = 1'b1;                  exp_q.push_back(v);  // fetch addr
    v = '0; v.wr_mdr = 1'b1; v.wr_pc = 1'b1;  exp_q.push_back(v);  // read, PC+1
    v = '0; v.wr_ir = 1'b1;                   exp_q.push_back(v);  // IR load
    v = '0;
    case (op)
      8'h01: begin v.wr_ac = 1'b1; v.ac_src = 2'd2; end
      8'h02: begin v.wr_ac = 1'b1; v.alu_ctl = 3'd5; v.wr_flags = 1'b1; end
      8'h0A: begin v.wr_ac = 1'b1; v.alu_b = 3'd1; v.wr_flags = 1'b1; end
      8'h0B: begin v.wr_ac = 1'b1; v.alu_b = 3'd1; v.alu_ctl = 3'd1; v.wr_flags = 1'b1; end
      default: ;
    endcase
    exp_q.push_back(v);
    if ((op >= 8'h03 && op <= 8'h09) || op == 8'h0C || op == 8'h0D) begin
      v = '0; v.wr_mar = 1'b1;                  exp_q.push_back(v);
      v = '0; v.wr_mdr = 1'b1; v.wr_pc = 1'b1;  exp_q.push_back(v);
      v = '0;
      if (op == 8'h0C) begin
        v.wr_pc = 1'b1; v.pc_src = 2'd1; exp_q.push_back(v);
      end else if (op == 8'h0D) begin
        v.wr_pc = 1'b1; v.pc_src = 2'd2; exp_q.push_back(v);
      end else begin
        v.wr_mar = 1'b1; v.mar_src = 1'b1; exp_q.push_back(v);
        v = '0; v.wr_mdr = 1'b1; v.mdr_src = (op == 8'h04) ? 2'd1 : 2'd0;
        exp_q.push_back(v);
        v = '0;
        if (op == 8'h04) v.wr_mem = 1'b1;
        else if (op == 8'h03) begin v.wr_ac = 1'b1; v.ac_src = 2'd1; end
        else begin
          v.wr_ac = 1'b1; v.wr_flags = 1'b1;
          v.alu_ctl = 3'(int'(op) - 5);
        end
        exp_q.push_back(v);
      end
    end
  endtask

  // Entered at a falling edge with the next rising edge moving into F0.
  // abort_at >= 0 pulses res asynchronously during that step.
  task automatic run_instr(input logic [7:0] op, input int abort_at);
    int n;
    build_seq(op);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (i == 0) begin
        #1 opcode = op;
      end
      @(negedge clk);
      chk($sformatf("op%02h_step%0d", op, i), got, exp_q[i]);
      if (i == abort_at) begin
        #10 res = 1'b1;
        #1 chk($sformatf("op%02h_abort_async", op), got, rst_vec());
        @(negedge clk);
        chk($sformatf("op%02h_abort_hold", op), got, rst_vec());
        res = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] op;
    n_chk  = 0;
    n_bad  = 0;
    res    = 1'b1;
    opcode = 8'h03;
    #10 chk("reset_async", got, rst_vec());
    @(negedge clk);  // t=100
    chk("reset_held_over_edge", got, rst_vec());
    res = 1'b0;

    // LOAD back-to-back shows the 9-cycle period
    run_instr(8'h03, -1);
    run_instr(8'h03, -1);
    run_instr(8'h04, -1);
    run_instr(8'h06, -1);
    run_instr(8'h0B, -1);
    run_instr(8'h0C, -1);
    run_instr(8'h0D, -1);
    run_instr(8'hFF, -1);
    run_instr(8'hFF, -1);
    run_instr(8'h01, -1);
    run_instr(8'h02, -1);
    run_instr(8'h0A, -1);
    run_instr(8'h00, -1);

    // LOAD aborted in A3
    run_instr(8'h03, 7);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) != 0) op = 8'($urandom_range(0, 15));
      else                           op = 8'($urandom_range(0, 255));
      if (op == 8'h0E) op = 8'h05;
      run_instr(op, -1);
    end

    // HALT parks with all outputs zero until reset
    run_instr(8'h0E, -1);
    for (int c = 0; c < 22; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("halt_idle%0d", c), got, out_t'(0));
    end
    #10 res = 1'b1;
    #1 chk("halt_async_reset", got, rst_vec());
    @(negedge clk);
    res = 1'b0;

    // Opcode change during A4 shows up in the same cycle
    build_seq(8'h05);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      if (i == 0) #1 opcode = 8'h05;
      @(negedge clk);
      if (i == 8) begin
        opcode = 8'h09;
        #1;
        build_seq(8'h09);
        chk("a4_comb_opcode", got, exp_q[8]);
      end
    end

    run_instr(8'h07, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
